// File: rtl/ntt_butterfly_unified_if.sv
// ntt_butterfly_unified_if
//   Operand/result bundle for one NTT butterfly lane.
//   master : stage controller (drives operands, receives results)
//   slave  : butterfly lane   (receives operands, drives results)
//   in_valid/mode/A/B/w : one operation per cycle, no backpressure
//   out_valid/a/b       : result, LAT cycles after the operation
interface ntt_butterfly_unified_if #(
    parameter int WIDTH = 30
) ();
    logic             in_valid;
    logic [1:0]       mode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] w;
    logic             out_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    modport master (output in_valid, mode, A, B, w, input out_valid, a, b);
    modport slave  (input in_valid, mode, A, B, w, output out_valid, a, b);
endinterface

// File: rtl/ntt_butterfly_unified.sv
// ntt_butterfly_unified
//   Fully pipelined modular butterfly, per-op mode select:
//     mode 00 = Cooley-Tukey  : a = A + B*w,  b = A - B*w
//     mode 01 = Gentleman-Sande: a = A + B,   b = (A - B)*w
//     mode 1x = bypass        : a = A,       b = B
//   All arithmetic mod Q. Latency LAT = MUL_LAT + 2, 1 op/cycle.
// Ports
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (clears valids and a/b)
//   bus  : slave side of ntt_butterfly_unified_if
module ntt_butterfly_unified #(
    parameter int WIDTH   = 30,
    parameter int Q       = 998244353,
    parameter int MUL_LAT = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    ntt_butterfly_unified_if.slave  bus
);
    localparam int LAT = MUL_LAT + 2;

    localparam logic [WIDTH:0]       QX = (WIDTH+1)'(Q);
    localparam logic [2*WIDTH-1:0]   QP = (2*WIDTH)'(Q);

    typedef struct packed {
        logic [1:0]       mode;
        logic [WIDTH-1:0] up;   // A or s
        logic [WIDTH-1:0] lo;   // multiplier operand, then product
    } lane_t;

    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= QX) s = s - QX;
        return s[WIDTH-1:0];
    endfunction

    // Borrow out of bit WIDTH flags a negative difference.
    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y);
        logic [WIDTH:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[WIDTH]) d = d + QX;
        return d[WIDTH-1:0];
    endfunction

    lane_t            pre_d, pre_q;
    logic [WIDTH-1:0] w_d, w_q;
    lane_t            mul_d [MUL_LAT];
    lane_t            mul_q [MUL_LAT];
    lane_t            fin;
    logic [LAT-1:0]   vld_d, vld_q;   // [0]=pre, [1..MUL_LAT]=mul, [LAT-1]=out
    logic [WIDTH-1:0] a_d, a_q, b_d, b_q;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] prod_red;

    // Pre-stage: GS folds the add/sub in before the multiply.
    always_comb begin
        pre_d.mode = bus.mode;
        pre_d.up   = bus.A;
        pre_d.lo   = bus.B;
        w_d        = bus.w;
        if (bus.mode == 2'b01) begin
            pre_d.up = mod_add(bus.A, bus.B);
            pre_d.lo = mod_sub(bus.A, bus.B);
        end
    end

    // Multiplier: exact direct reduction, followed by MUL_LAT register
    // stages so synthesis retiming can distribute the multiply/modulo.
    always_comb begin
        prod     = {{WIDTH{1'b0}}, pre_q.lo} * {{WIDTH{1'b0}}, w_q};
        prod_red = WIDTH'(prod % QP);
        mul_d[0] = pre_q;
        if (!pre_q.mode[1]) mul_d[0].lo = prod_red;
        for (int i = 1; i < MUL_LAT; i++) mul_d[i] = mul_q[i-1];
    end

    // Post-stage: only CT needs a final add/sub; a/b hold when idle.
    always_comb begin
        fin   = mul_q[MUL_LAT-1];
        a_d   = a_q;
        b_d   = b_q;
        vld_d = {vld_q[LAT-2:0], bus.in_valid};
        if (vld_q[LAT-2]) begin
            if (fin.mode == 2'b00) begin
                a_d = mod_add(fin.up, fin.lo);
                b_d = mod_sub(fin.up, fin.lo);
            end else begin
                a_d = fin.up;
                b_d = fin.lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    // Data path carries no reset; validity is tracked by vld_q alone.
    always_ff @(posedge clk) begin
        pre_q <= pre_d;
        w_q   <= w_d;
        for (int i = 0; i < MUL_LAT; i++) mul_q[i] <= mul_d[i];
    end

    assign bus.out_valid = vld_q[LAT-1];
    assign bus.a         = a_q;
    assign bus.b         = b_q;
endmodule

// File: tb/tb_ntt_butterfly_unified.sv
module tb_ntt_butterfly_unified;
    localparam int     WIDTH   = 30;
    localparam int     QI      = 998244353;
    localparam longint QL      = 64'(QI);
    localparam int     MUL_LAT = 6;
    localparam int     LAT     = MUL_LAT + 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_butterfly_unified_if #(.WIDTH(WIDTH)) bus ();

    ntt_butterfly_unified #(.WIDTH(WIDTH), .Q(QI), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int               due;
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_acc  = 0;
    int   n_out  = 0;

    // Reference butterfly in plain 64-bit arithmetic.
    function automatic void model(input logic [1:0] m, input longint x, input longint y,
                                  input longint t, output longint ra, output longint rb);
        longint p;
        if (m == 2'b00) begin
            p  = (y * t) % QL;
            ra = (x + p) % QL;
            rb = (x - p + QL) % QL;
        end else if (m == 2'b01) begin
            ra = (x + y) % QL;
            rb = (((x - y + QL) % QL) * t) % QL;
        end else begin
            ra = x;
            rb = y;
        end
    endfunction

    // Model: every accepted op is due LAT-1 edges after its capture edge
    // (visible at the following negedge). Reset discards everything queued.
    initial begin
        longint ra, rb;
        exp_t   e;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst === 1'b1) begin
                n_acc -= q.size();
                q.delete();
            end else if (bus.in_valid === 1'b1) begin
                model(bus.mode, 64'(bus.A), 64'(bus.B), 64'(bus.w), ra, rb);
                e.due = cyc + LAT - 1;
                e.ea  = WIDTH'(ra);
                e.eb  = WIDTH'(rb);
                q.push_back(e);
                n_acc++;
            end
        end
    end

    // Compare process.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                n_out++;
                checks++;
                if (q.size() == 0 || q[0].due != cyc) begin
                    errors++;
                    $display("FAIL unexpected_valid cyc=%0d a=%0d b=%0d", cyc, bus.a, bus.b);
                end else begin
                    if (bus.a !== q[0].ea || bus.b !== q[0].eb ||
                        64'(bus.a) >= QL || 64'(bus.b) >= QL) begin
                        errors++;
                        $display("FAIL result cyc=%0d got a=%0d b=%0d want a=%0d b=%0d",
                                 cyc, bus.a, bus.b, q[0].ea, q[0].eb);
                    end
                    void'(q.pop_front());
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_valid cyc=%0d due=%0d", cyc, q[0].due);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [1:0] m, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] t);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.mode     = m;
        bus.A        = x;
        bus.B        = y;
        bus.w        = t;
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        return WIDTH'($urandom_range(QI - 1));
    endfunction

    // One isolated op, checked against hand-computed literals and latency.
    task automatic single(input string nm, input logic [1:0] m, input logic [WIDTH-1:0] x,
                          input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] t,
                          input logic [WIDTH-1:0] ea, input logic [WIDTH-1:0] eb);
        int s;
        int got_cyc;
        bit got;
        drive(1'b1, m, x, y, t);
        s = cyc;
        drive(1'b0, 2'b00, '0, '0, '0);
        got = 1'b0;
        got_cyc = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                got = 1'b1;
                got_cyc = cyc;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no out_valid within 20 cycles", nm);
        end else if (got_cyc != s + LAT || bus.a !== ea || bus.b !== eb) begin
            errors++;
            $display("FAIL %s got lat=%0d a=%0d b=%0d want lat=%0d a=%0d b=%0d",
                     nm, got_cyc - s, bus.a, bus.b, LAT, ea, eb);
        end
    endtask

    initial begin
        longint ra, rb;
        int     s;
        bit     bad;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode = 2'b00;
        bus.A = '0;
        bus.B = '0;
        bus.w = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.a !== '0 || bus.b !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%0b a=%0d b=%0d want 0 0 0",
                     bus.out_valid, bus.a, bus.b);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // Pin the model itself to hand-computed values.
        model(2'b00, 5, 3, 2, ra, rb);
        checks++;
        if (ra != 11 || rb != QL - 1) begin
            errors++;
            $display("FAIL model_ct got %0d %0d want 11 %0d", ra, rb, QL - 1);
        end
        model(2'b01, QL - 1, 1, 7, ra, rb);
        checks++;
        if (ra != 0 || rb != 998244339) begin
            errors++;
            $display("FAIL model_gs_wrap got %0d %0d want 0 998244339", ra, rb);
        end

        // Directed vectors.
        single("ct_basic",  2'b00, 30'd5,         30'd3,   30'd2,         30'd11,        30'd998244352);
        single("gs_basic",  2'b01, 30'd5,         30'd3,   30'd2,         30'd8,         30'd4);
        single("gs_wrap",   2'b01, 30'd998244352, 30'd1,   30'd7,         30'd0,         30'd998244339);
        single("ct_wrap",   2'b00, 30'd0,         30'd1,   30'd998244352, 30'd998244352, 30'd1);
        single("bypass",    2'b10, 30'd123,       30'd456, 30'd9,         30'd123,       30'd456);
        single("mode11",    2'b11, 30'd123,       30'd456, 30'd9,         30'd123,       30'd456);

        // Throughput: 16 back-to-back ops, mode cycling CT/GS/bypass.
        @(posedge clk);
        #1;
        s = cyc;
        bus.in_valid = 1'b1;
        bus.mode = 2'b00;
        bus.A = rnd();
        bus.B = rnd();
        bus.w = rnd();
        fork
            begin
                for (int i = 1; i < 16; i++) begin
                    logic [1:0] m;
                    m = (i % 3 == 0) ? 2'b00 : (i % 3 == 1) ? 2'b01 : 2'b10;
                    drive(1'b1, m, rnd(), rnd(), rnd());
                end
                drive(1'b0, 2'b00, '0, '0, '0);
            end
            begin
                for (int c = 0; c <= LAT + 16; c++) begin
                    bit ev;
                    @(negedge clk);
                    ev = (c >= LAT && c < LAT + 16);
                    checks++;
                    if (bus.out_valid !== ev || cyc != s + c) begin
                        errors++;
                        $display("FAIL throughput_valid offset=%0d got %0b want %0b", c, bus.out_valid, ev);
                    end
                end
            end
        join

        // Reset mid-stream, with in_valid high during reset.
        for (int i = 0; i < 5; i++) drive(1'b1, 2'($urandom_range(3)), rnd(), rnd(), rnd());
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.A = rnd();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.a !== '0 || bus.b !== '0) begin
            errors++;
            $display("FAIL midreset_state got v=%0b a=%0d b=%0d want 0 0 0",
                     bus.out_valid, bus.a, bus.b);
        end
        bad = 1'b0;
        for (int k = 0; k < LAT + 2; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL midreset_flush got out_valid=1 want 0 after reset");
        end
        single("post_reset", 2'b00, 30'd5, 30'd3, 30'd2, 30'd11, 30'd998244352);

        // Random soak with gaps and all four modes.
        for (int i = 0; i < 10000; i++)
            drive($urandom_range(3) != 0, 2'($urandom_range(3)), rnd(), rnd(), rnd());
        repeat (LAT + 4) drive(1'b0, 2'b00, '0, '0, '0);
        @(negedge clk);
        checks++;
        if (q.size() != 0 || n_out != n_acc) begin
            errors++;
            $display("FAIL soak_count got outputs=%0d pending=%0d want outputs=%0d pending=0",
                     n_out, q.size(), n_acc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
